// File: rtl/irq_controller.sv
// irq_controller: 8-line programmable interrupt front end.
// Latches edge/level interrupts, masks with enable, arbitrates by fixed
// priority (line 7 highest) above the current in-service level, and drives
// a valid/ack request to the core. Nested in-service levels pop on ret.
module irq_controller #(
    parameter int unsigned N_IRQ    = 8,
    parameter logic [4:0]  VEC_BASE = 5'b10000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] irq_in,
    input  logic       cfg_we,
    input  logic [1:0] cfg_addr,
    input  logic [7:0] cfg_wdata,
    output logic [7:0] cfg_rdata,
    output logic       irq_req,
    output logic [2:0] irq_id,
    output logic [4:0] irq_addr,
    input  logic       irq_ack,
    input  logic       ret
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        SETTLE = 2'd2
    } state_e;

    state_e     state_q;
    logic       irq_req_q;
    logic [2:0] irq_id_q;
    logic [4:0] irq_addr_q;

    logic [7:0] enable_q,     enable_d;
    logic [7:0] edge_sel_q,   edge_sel_d;
    logic [7:0] pending_q,    pending_d;
    logic [7:0] in_service_q, in_service_d;
    logic [7:0] irq_q;

    logic [7:0] cand;
    logic [7:0] clr;
    logic [7:0] rise;
    logic       top_valid;
    logic [2:0] top_idx;
    logic       winner_valid;
    logic [2:0] winner_id;
    logic       ack_fire;

    // Priority arbitration: highest in-service level, then highest candidate above it
    always_comb begin
        cand      = pending_q & enable_q;
        top_valid = 1'b0;
        top_idx   = '0;
        for (int unsigned i = 0; i < N_IRQ; i++) begin
            if (in_service_q[i]) begin
                top_valid = 1'b1;
                top_idx   = 3'(i);
            end
        end
        winner_valid = 1'b0;
        winner_id    = '0;
        for (int unsigned i = 0; i < N_IRQ; i++) begin
            if (cand[i] && (!top_valid || (3'(i) > top_idx))) begin
                winner_valid = 1'b1;
                winner_id    = 3'(i);
            end
        end
    end

    assign ack_fire = (state_q == REQ) && irq_ack;

    // Next-state for config, pending and in-service registers
    always_comb begin
        enable_d   = enable_q;
        edge_sel_d = edge_sel_q;
        if (cfg_we && (cfg_addr == 2'd0)) enable_d   = cfg_wdata;
        if (cfg_we && (cfg_addr == 2'd1)) edge_sel_d = cfg_wdata;

        clr = '0;
        if (cfg_we && (cfg_addr == 2'd2)) clr = cfg_wdata;
        if (ack_fire) clr[irq_id_q] = 1'b1;
        rise = irq_in & ~irq_q;

        // Edge lines: sticky with set winning over clear; level lines follow irq_in
        pending_d = (edge_sel_q & ((pending_q & ~clr) | rise))
                  | (~edge_sel_q & irq_in);

        // ret pops the old top level before the acked level is pushed
        in_service_d = in_service_q;
        if (ret && top_valid) in_service_d[top_idx] = 1'b0;
        if (ack_fire) in_service_d[irq_id_q] = 1'b1;
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            enable_q     <= '0;
            edge_sel_q   <= '0;
            pending_q    <= '0;
            in_service_q <= '0;
            irq_q        <= '0;
        end else begin
            enable_q     <= enable_d;
            edge_sel_q   <= edge_sel_d;
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
            irq_q        <= irq_in;
        end
    end

    // Request FSM with registered request, id and handler address
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            irq_req_q  <= 1'b0;
            irq_id_q   <= '0;
            irq_addr_q <= VEC_BASE;
        end else begin
            case (state_q)
                IDLE: begin
                    irq_req_q <= 1'b0;
                    if (winner_valid) begin
                        state_q    <= REQ;
                        irq_req_q  <= 1'b1;
                        irq_id_q   <= winner_id;
                        irq_addr_q <= VEC_BASE + {2'b00, winner_id};
                    end
                end
                REQ: begin
                    if (irq_ack) begin
                        state_q   <= SETTLE;
                        irq_req_q <= 1'b0;
                    end else if (!winner_valid) begin
                        state_q   <= IDLE;
                        irq_req_q <= 1'b0;
                    end else begin
                        irq_id_q   <= winner_id;
                        irq_addr_q <= VEC_BASE + {2'b00, winner_id};
                    end
                end
                SETTLE: begin
                    state_q   <= IDLE;
                    irq_req_q <= 1'b0;
                end
                default: begin
                    state_q   <= IDLE;
                    irq_req_q <= 1'b0;
                end
            endcase
        end
    end

    // Register read mux
    always_comb begin
        case (cfg_addr)
            2'd0:    cfg_rdata = enable_q;
            2'd1:    cfg_rdata = edge_sel_q;
            2'd2:    cfg_rdata = pending_q;
            default: cfg_rdata = in_service_q;
        endcase
    end

    assign irq_req  = irq_req_q;
    assign irq_id   = irq_id_q;
    assign irq_addr = irq_addr_q;

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: expected values are queued as
// stimulus is applied and popped when the DUT outputs are sampled.
module tb_irq_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] irq_in;
    logic       cfg_we;
    logic [1:0] cfg_addr;
    logic [7:0] cfg_wdata;
    logic [7:0] cfg_rdata;
    logic       irq_req;
    logic [2:0] irq_id;
    logic [4:0] irq_addr;
    logic       irq_ack;
    logic       ret;

    logic [8:0] sb[$];
    int         n_cmp = 0;
    int         n_bad = 0;

    irq_controller #(.N_IRQ(8), .VEC_BASE(5'b10000)) dut (
        .clk       (clk),
        .reset     (reset),
        .irq_in    (irq_in),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .irq_req   (irq_req),
        .irq_id    (irq_id),
        .irq_addr  (irq_addr),
        .irq_ack   (irq_ack),
        .ret       (ret)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [8:0] v);
        cfg_addr = a;
        #1;
        v = {1'b0, cfg_rdata};
    endtask

    function automatic logic [8:0] obs();
        return {irq_req, irq_id, irq_addr};
    endfunction

    task automatic test_reset();
        logic [8:0] e, v;
        reset = 1'b1;
        tick(); tick();
        sb.push_back({1'b0, 3'd0, 5'b10000});
        e = sb.pop_front(); n_cmp++;
        if (obs() !== e) begin n_bad++; $display("FAIL reset_out: got %h want %h", obs(), e); end
        for (int a = 0; a < 4; a++) begin
            sb.push_back(9'h000);
            rd(2'(a), v);
            e = sb.pop_front(); n_cmp++;
            if (v !== e) begin n_bad++; $display("FAIL reset_reg%0d: got %h want %h", a, v, e); end
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic_edge();
        logic [8:0] e, v;
        wr(2'd0, 8'h04);
        wr(2'd1, 8'h04);
        irq_in = 8'h04;
        sb.push_back(9'h004);
        tick();
        irq_in = 8'h00;
        rd(2'd2, v);
        e = sb.pop_front(); n_cmp++;
        if (v !== e) begin n_bad++; $display("FAIL basic_pending: got %h want %h", v, e); end
        // ack while still IDLE must be ignored
        irq_ack = 1'b1;
        sb.push_back({1'b1, 3'd2, 5'b10010});
        sb.push_back(9'h000);
        tick();
        irq_ack = 1'b0;
        e = sb.pop_front(); n_cmp++;
        if (obs() !== e) begin n_bad++; $display("FAIL basic_req: got %h want %h", obs(), e); end
        rd(2'd3, v);
        e = sb.pop_front(); n_cmp++;
        if (v !== e) begin n_bad++; $display("FAIL ack_idle_ignored: got %h want %h", v, e); end
        irq_ack = 1'b1;
        sb.push_back(9'h004);
        sb.push_back(9'h000);
        sb.push_back({1'b0, 3'd2, 5'b10010});
        tick();
        irq_ack = 1'b0;
        rd(2'd3, v);
        e = sb.pop_front(); n_cmp++;
        if (v !== e) begin n_bad++; $display("FAIL basic_inservice: got %h want %h", v, e); end
        rd(2'd2, v);
        e = sb.pop_front(); n_cmp++;
        if (v !== e) begin n_bad++; $display("FAIL basic_pend_clr: got %h want %h", v, e); end
        e = sb.pop_front(); n_cmp++;
        if (obs() !== e) begin n_bad++; $display("FAIL basic_settle: got %h want %h", obs(), e); end
        tick();
        ret = 1'b1;
        sb.push_back(9'h000);
        tick();
        ret = 1'b0;
        rd(2'd3, v);
        e = sb.pop_front(); n_cmp++;
        if (v !== e) begin n_bad++; $display("FAIL basic_ret: got %h want %h", v, e); end
    endtask

    task automatic test_priority();
        logic [8:0] e, v;
        wr(2'd0, 8'hFF);
        wr(2'd1, 8'hFF);
        irq_in = 8'h42;
        tick();
        irq_in = 8'h00;
        sb.push_back({1'b1, 3'd6, 5'b10110});
        tick();
        e = sb.pop_front(); n_cmp++;
        if (obs() !== e) begin n_bad++; $display("FAIL prio_id6: got %h want %h", obs(), e); end
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        tick(); tick(); tick();
        sb.push_back({1'b0, 3'd6, 5'b10110});
        sb.push_back(9'h002);
        e = sb.pop_front(); n_cmp++;
        if (obs() !== e) begin n_bad++; $display("FAIL prio_blocked: got %h want %h", obs(), e); end
        rd(2'd2, v);
        e = sb.pop_front(); n_cmp++;
        if (v !== e) begin n_bad++; $display("FAIL prio_pend1: got %h want %h", v, e); end
        ret = 1'b1;
        sb.push_back(9'h000);
        tick();
        ret = 1'b0;
        rd(2'd3, v);
        e = sb.pop_front(); n_cmp++;
        if (v !== e) begin n_bad++; $display("FAIL prio_ret: got %h want %h", v, e); end
        sb.push_back({1'b1, 3'd1, 5'b10001});
        tick();
        e = sb.pop_front(); n_cmp++;
        if (obs() !== e) begin n_bad++; $display("FAIL prio_id1: got %h want %h", obs(), e); end
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        ret = 1'b1;
        tick();
        ret = 1'b0;
        tick();
    endtask

    task automatic test_preempt();
        logic [8:0] e, v;
        irq_in = 8'h08; tick(); irq_in = 8'h00; tick();
        irq_ack = 1'b1; tick(); irq_ack = 1'b0; tick();
        irq_in = 8'h20;
        tick();
        irq_in = 8'h00;
        sb.push_back({1'b1, 3'd5, 5'b10101});
        tick();
        e = sb.pop_front(); n_cmp++;
        if (obs() !== e) begin n_bad++; $display("FAIL preempt_id5: got %h want %h", obs(), e); end
        irq_ack = 1'b1;
        sb.push_back(9'h028);
        tick();
        irq_ack = 1'b0;
        rd(2'd3, v);
        e = sb.pop_front(); n_cmp++;
        if (v !== e) begin n_bad++; $display("FAIL preempt_is28: got %h want %h", v, e); end
        tick();
        ret = 1'b1;
        sb.push_back(9'h008);
        tick();
        rd(2'd3, v);
        e = sb.pop_front(); n_cmp++;
        if (v !== e) begin n_bad++; $display("FAIL preempt_ret1: got %h want %h", v, e); end
        sb.push_back(9'h000);
        tick();
        ret = 1'b0;
        rd(2'd3, v);
        e = sb.pop_front(); n_cmp++;
        if (v !== e) begin n_bad++; $display("FAIL preempt_ret2: got %h want %h", v, e); end
    endtask

    task automatic test_replace();
        logic [8:0] e;
        wr(2'd1, 8'h00);
        irq_in = 8'h04;
        sb.push_back({1'b1, 3'd2, 5'b10010});
        tick(); tick();
        e = sb.pop_front(); n_cmp++;
        if (obs() !== e) begin n_bad++; $display("FAIL level_id2: got %h want %h", obs(), e); end
        irq_in = 8'h84;
        sb.push_back({1'b1, 3'd7, 5'b10111});
        tick(); tick();
        e = sb.pop_front(); n_cmp++;
        if (obs() !== e) begin n_bad++; $display("FAIL level_id7: got %h want %h", obs(), e); end
        irq_in = 8'h00;
        sb.push_back({1'b0, 3'd7, 5'b10111});
        tick(); tick();
        e = sb.pop_front(); n_cmp++;
        if (obs() !== e) begin n_bad++; $display("FAIL level_drop: got %h want %h", obs(), e); end
    endtask

    task automatic test_w1c_race();
        logic [8:0] e, v;
        wr(2'd0, 8'h00);
        wr(2'd1, 8'hFF);
        irq_in = 8'h10; tick(); irq_in = 8'h00; tick();
        cfg_we = 1'b1; cfg_addr = 2'd2; cfg_wdata = 8'h10; irq_in = 8'h10;
        sb.push_back(9'h010);
        tick();
        cfg_we = 1'b0; irq_in = 8'h00;
        rd(2'd2, v);
        e = sb.pop_front(); n_cmp++;
        if (v !== e) begin n_bad++; $display("FAIL w1c_set_wins: got %h want %h", v, e); end
        sb.push_back(9'h000);
        wr(2'd2, 8'h10);
        rd(2'd2, v);
        e = sb.pop_front(); n_cmp++;
        if (v !== e) begin n_bad++; $display("FAIL w1c_clear: got %h want %h", v, e); end
        wr(2'd0, 8'hFF);
    endtask

    task automatic test_back_to_back();
        logic [8:0] e, v;
        irq_in = 8'h01; tick(); irq_in = 8'h00; tick();
        irq_ack = 1'b1; tick(); irq_ack = 1'b0; tick();
        irq_in = 8'h08; tick(); irq_in = 8'h00;
        sb.push_back({1'b1, 3'd3, 5'b10011});
        tick();
        e = sb.pop_front(); n_cmp++;
        if (obs() !== e) begin n_bad++; $display("FAIL nest_id3: got %h want %h", obs(), e); end
        irq_ack = 1'b1; ret = 1'b1;
        sb.push_back(9'h008);
        tick();
        irq_ack = 1'b0; ret = 1'b0;
        rd(2'd3, v);
        e = sb.pop_front(); n_cmp++;
        if (v !== e) begin n_bad++; $display("FAIL ret_ack_same: got %h want %h", v, e); end
        tick();
        irq_in = 8'h80; tick(); irq_in = 8'h00;
        sb.push_back({1'b1, 3'd7, 5'b10111});
        tick();
        e = sb.pop_front(); n_cmp++;
        if (obs() !== e) begin n_bad++; $display("FAIL midreq_req: got %h want %h", obs(), e); end
        reset = 1'b1;
        sb.push_back({1'b0, 3'd0, 5'b10000});
        tick();
        reset = 1'b0;
        e = sb.pop_front(); n_cmp++;
        if (obs() !== e) begin n_bad++; $display("FAIL midreq_reset_out: got %h want %h", obs(), e); end
        for (int a = 0; a < 4; a++) begin
            sb.push_back(9'h000);
            rd(2'(a), v);
            e = sb.pop_front(); n_cmp++;
            if (v !== e) begin n_bad++; $display("FAIL midreq_reset_reg%0d: got %h want %h", a, v, e); end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; irq_in = '0; cfg_we = 1'b0; cfg_addr = '0;
        cfg_wdata = '0; irq_ack = 1'b0; ret = 1'b0;
        test_reset();
        test_basic_edge();
        test_priority();
        test_preempt();
        test_replace();
        test_w1c_race();
        test_back_to_back();
        if (sb.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
